// File: rtl/axi_rw_arbiter.sv
// Memory-port arbiter between an AXI write engine and read engine.
// One burst owns the port at a time; ties alternate so neither side starves.
module axi_rw_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic       ACLK,
    input  logic       ARESTN,
    input  logic       wr_req,
    input  logic [7:0] wr_len,
    input  logic       wr_beat,
    input  logic       rd_req,
    input  logic [7:0] rd_len,
    input  logic       rd_beat,
    output logic       wr_gnt,
    output logic       rd_gnt,
    output logic [7:0] beats_left,
    output logic       busy,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] beats_left_reg;
    logic       pri_rd_reg;
    logic       proto_err_reg;

    // The arbiter never touches the data path; widths only document the port it guards.
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_width_guard
    end

    always_ff @(posedge ACLK or negedge ARESTN) begin
        if (!ARESTN) begin
            state_reg      <= IDLE;
            beats_left_reg <= 8'd0;
            pri_rd_reg     <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_beat || rd_beat)
                        proto_err_reg <= 1'b1;
                    if (wr_req && (!rd_req || !pri_rd_reg)) begin
                        state_reg      <= WR_BURST;
                        beats_left_reg <= wr_len;
                    end else if (rd_req) begin
                        state_reg      <= RD_BURST;
                        beats_left_reg <= rd_len;
                    end
                end
                WR_BURST: begin
                    if (rd_beat)
                        proto_err_reg <= 1'b1;
                    if (wr_beat) begin
                        if (beats_left_reg != 8'd0) begin
                            beats_left_reg <= beats_left_reg - 8'd1;
                        end else begin
                            // Last beat: hand over to the reader without an idle bubble.
                            pri_rd_reg <= 1'b1;
                            if (rd_req) begin
                                state_reg      <= RD_BURST;
                                beats_left_reg <= rd_len;
                            end else if (wr_req) begin
                                beats_left_reg <= wr_len;
                            end else begin
                                state_reg      <= IDLE;
                                beats_left_reg <= 8'd0;
                            end
                        end
                    end
                end
                RD_BURST: begin
                    if (wr_beat)
                        proto_err_reg <= 1'b1;
                    if (rd_beat) begin
                        if (beats_left_reg != 8'd0) begin
                            beats_left_reg <= beats_left_reg - 8'd1;
                        end else begin
                            pri_rd_reg <= 1'b0;
                            if (wr_req) begin
                                state_reg      <= WR_BURST;
                                beats_left_reg <= wr_len;
                            end else if (rd_req) begin
                                beats_left_reg <= rd_len;
                            end else begin
                                state_reg      <= IDLE;
                                beats_left_reg <= 8'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    beats_left_reg <= 8'd0;
                end
            endcase
        end
    end

    assign wr_gnt     = (state_reg == WR_BURST);
    assign rd_gnt     = (state_reg == RD_BURST);
    assign busy       = (state_reg != IDLE);
    assign beats_left = beats_left_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed and randomized checks of axi_rw_arbiter against a burst-level model.
module tb_axi_rw_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESTN = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_len = 8'd0;
    logic       wr_beat = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_len = 8'd0;
    logic       rd_beat = 1'b0;
    logic       wr_gnt;
    logic       rd_gnt;
    logic [7:0] beats_left;
    logic       busy;
    logic       proto_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: who owns the port (0 none, 1 write, 2 read), burst length and beats consumed.
    int m_owner = 0;
    int m_len = 0;
    int m_done = 0;
    bit m_pri = 1'b0;
    bit m_err = 1'b0;

    axi_rw_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESTN(ARESTN),
        .wr_req(wr_req), .wr_len(wr_len), .wr_beat(wr_beat),
        .rd_req(rd_req), .rd_len(rd_len), .rd_beat(rd_beat),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .beats_left(beats_left),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int exp_left;
        exp_left = (m_owner == 0) ? 0 : (m_len - m_done);
        chk({tag, ".wr_gnt"}, int'(wr_gnt), int'(m_owner == 1));
        chk({tag, ".rd_gnt"}, int'(rd_gnt), int'(m_owner == 2));
        chk({tag, ".busy"}, int'(busy), int'(m_owner != 0));
        chk({tag, ".beats_left"}, int'(beats_left), exp_left);
        chk({tag, ".proto_err"}, int'(proto_err), int'(m_err));
        $display("txn %s: wr_gnt=%0d rd_gnt=%0d beats_left=%0d err=%0d", tag, wr_gnt, rd_gnt, beats_left, proto_err);
    endtask

    task automatic model_step(input bit wq, input int wl, input bit wb, input bit rq, input int rl, input bit rb);
        int pick;
        pick = -1;
        if (m_owner == 0) begin
            if (wb || rb) m_err = 1'b1;
            if (wq && rq) pick = m_pri ? 2 : 1;
            else if (wq)  pick = 1;
            else if (rq)  pick = 2;
        end else begin
            bit own_b, foreign_b, own_q, other_q;
            own_b     = (m_owner == 1) ? wb : rb;
            foreign_b = (m_owner == 1) ? rb : wb;
            own_q     = (m_owner == 1) ? wq : rq;
            other_q   = (m_owner == 1) ? rq : wq;
            if (foreign_b) m_err = 1'b1;
            if (own_b) begin
                if (m_done < m_len) begin
                    m_done++;
                end else begin
                    m_pri = (m_owner == 1);
                    if (other_q)    pick = 3 - m_owner;
                    else if (own_q) pick = m_owner;
                    else            m_owner = 0;
                end
            end
        end
        if (pick > 0) begin
            m_owner = pick;
            m_len   = (pick == 1) ? wl : rl;
            m_done  = 0;
        end
    endtask

    // Drive one cycle of inputs, advance model at the edge, check just after it.
    task automatic step(input string tag, input bit wq, input int wl, input bit wb,
                        input bit rq, input int rl, input bit rb);
        wr_req = wq; wr_len = 8'(wl); wr_beat = wb;
        rd_req = rq; rd_len = 8'(rl); rd_beat = rb;
        @(posedge ACLK);
        model_step(wq, wl, wb, rq, rl, rb);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        wr_req = 0; wr_beat = 0; rd_req = 0; rd_beat = 0; wr_len = 0; rd_len = 0;
        ARESTN = 1'b0;
        m_owner = 0; m_len = 0; m_done = 0; m_pri = 0; m_err = 0;
        #1;
        check_all("reset");
        @(posedge ACLK);
        #1;
        ARESTN = 1'b1;
    endtask

    initial begin
        int beats_seen;
        int guard;
        #2;
        do_reset();

        // Single write burst of 4 beats.
        step("wr1_req", 1, 3, 0, 0, 0, 0);
        chk("wr1_first_left", int'(beats_left), 3);
        for (int i = 0; i < 4; i++) step("wr1_beat", 0, 0, 1, 0, 0, 0);
        chk("wr1_done_gnt", int'(wr_gnt), 0);

        // Tie from reset: write first, read straight after, then write wins again.
        do_reset();
        step("tie_req", 1, 0, 0, 1, 0, 0);
        chk("tie_first_wr", int'(wr_gnt), 1);
        step("tie_wbeat", 0, 0, 1, 1, 0, 0);
        chk("tie_then_rd", int'(rd_gnt), 1);
        step("tie_rbeat", 0, 0, 0, 0, 0, 1);
        step("tie_again", 1, 0, 0, 1, 0, 0);
        chk("tie_pri_back", int'(wr_gnt), 1);
        step("tie_end", 0, 0, 1, 0, 0, 0);

        // Fairness: both requesting continuously, len 1.
        do_reset();
        step("fair_req", 1, 1, 0, 1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 2; b++) begin
                chk("fair_owner_wr", int'(wr_gnt), int'(k % 2 == 0));
                chk("fair_owner_rd", int'(rd_gnt), int'(k % 2 == 1));
                step("fair_beat", 1, 1, m_owner == 1, 1, 1, m_owner == 2);
            end
        end

        // Protocol error: read beat during a write burst.
        do_reset();
        step("perr_req", 1, 4, 0, 0, 0, 0);
        step("perr_wbeat", 0, 0, 1, 0, 0, 0);
        step("perr_rbeat", 0, 0, 0, 0, 0, 1);
        chk("perr_flag", int'(proto_err), 1);
        chk("perr_left", int'(beats_left), 3);
        for (int i = 0; i < 4; i++) step("perr_drain", 0, 0, 1, 0, 0, 0);
        chk("perr_sticky", int'(proto_err), 1);

        // Asynchronous reset in the middle of a write burst.
        do_reset();
        step("arst_req", 1, 7, 0, 0, 0, 0);
        step("arst_b1", 0, 0, 1, 0, 0, 0);
        step("arst_b2", 0, 0, 1, 0, 0, 0);
        chk("arst_pre_left", int'(beats_left), 5);
        #1;
        do_reset();
        chk("arst_idle_gnt", int'(wr_gnt), 0);
        step("arst_after", 0, 0, 0, 0, 0, 0);
        step("arst_regrant", 1, 2, 0, 0, 0, 0);
        chk("arst_new_len", int'(beats_left), 2);

        // Maximum-length read burst with random gaps.
        do_reset();
        step("max_req", 0, 0, 0, 1, 255, 0);
        beats_seen = 0;
        guard = 0;
        while (beats_seen < 256 && guard < 3000) begin
            bit rb;
            rb = ($urandom_range(0, 2) != 0);
            if (rb) beats_seen++;
            step("max_beat", 0, 0, 0, 0, 0, rb);
            if (beats_seen < 256) chk("max_held", int'(rd_gnt), 1);
            guard++;
        end
        chk("max_budget", int'(beats_seen), 256);
        chk("max_released", int'(rd_gnt), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bit wq, rq, wb, rb;
            wq = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            wb = (m_owner == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
            rb = (m_owner == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
            step("rand", wq, $urandom_range(0, 3), wb, rq, $urandom_range(0, 3), rb);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_rw_arbiter.md
AXI_RW_ARBITER -- requirements
Module: axi_rw_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, address width of the shared memory port.
REQ-002 Parameter: DATA_WIDTH, default 32, data width of the shared memory port (pass-through only, no arithmetic).
REQ-003 ACLK  input  1  sole clock; all state updates on posedge.
REQ-004 ARESTN  input  1  asynchronous active-low reset.
REQ-005 wr_req  input  1  write engine holds an accepted AW burst awaiting memory access.
REQ-006 wr_len  input  8  AWLEN of the pending write burst (beats = wr_len+1).
REQ-007 wr_beat  input  1  write engine consumes one memory beat this cycle.
REQ-008 rd_req  input  1  read engine holds an accepted AR burst awaiting memory access.
REQ-009 rd_len  input  8  ARLEN of the pending read burst (beats = rd_len+1).
REQ-010 rd_beat  input  1  read engine consumes one memory beat this cycle.
REQ-011 wr_gnt  output  1  write engine owns the memory port.
REQ-012 rd_gnt  output  1  read engine owns the memory port.
REQ-013 beats_left  output  8  remaining beats after the current one in the granted burst.
REQ-014 busy  output  1  a burst is granted (wr_gnt | rd_gnt).
REQ-015 proto_err  output  1  sticky: beat outside grant or beat after burst end.

Function
REQ-016 FSM states: IDLE, WR_BURST, RD_BURST; wr_gnt = (state==WR_BURST), rd_gnt = (state==RD_BURST), both registered-state decodes, never both 1.
REQ-017 Priority flag pri_rd (1 bit): 0 = write wins a tie, 1 = read wins a tie; toggles to favour the other side each time a burst completes.
REQ-018 IDLE: only wr_req -> WR_BURST; only rd_req -> RD_BURST; both -> side selected by pri_rd; neither -> stay IDLE.
REQ-019 On entry to a burst state, beats_left loads the granted side's len, sampled in the transition cycle; grant visible one cycle after req is first seen in IDLE.
REQ-020 In burst state, each owner beat with beats_left>0 decrements beats_left by 1; beats with no owner-side beat hold beats_left.
REQ-021 Owner beat with beats_left==0 ends the burst: next state = other side's burst state if its req is high (back-to-back, no IDLE bubble, len loaded that cycle), else own burst state if own req still high, else IDLE.
REQ-022 A granted burst is never preempted; req deassertion mid-burst is ignored until burst end.
REQ-023 wr_len=255 / rd_len=255 yields exactly 256 beats; 8-bit counter never wraps below 0.
REQ-024 Beat on the non-owning side, or any beat in IDLE, sets proto_err and does not change state or beats_left.
REQ-025 beats_left reads 0 in IDLE.

Reset
REQ-026 ARESTN low asynchronously forces state=IDLE, wr_gnt=0, rd_gnt=0, busy=0, beats_left=0, pri_rd=0, proto_err=0, including mid-burst.
REQ-027 After ARESTN deasserts, first arbitration decision occurs on the first posedge with ARESTN high; in-flight burst state is not retained.
REQ-028 proto_err clears only on reset.

Verification
REQ-029 Single write: wr_req=1, wr_len=3, wr_beat x4 -> wr_gnt high 1 cycle after req, beats_left 3,2,1,0, IDLE after 4th beat, proto_err=0.
REQ-030 Tie: wr_req=rd_req=1 from reset, both len=0 -> WR_BURST first, then RD_BURST directly on write's beat with no IDLE cycle, then pri_rd=0 again.
REQ-031 Max burst: rd_req, rd_len=255, 256 rd_beats with random gaps -> rd_gnt held exactly until 256th beat, beats_left never underflows.
REQ-032 Fairness: both reqs held high, len=1 each -> grants alternate W,R,W,R with 2 beats each, no bubbles.
REQ-033 Protocol error: rd_beat=1 during WR_BURST -> proto_err=1 sticky, write beats_left unchanged.
REQ-034 Reset mid-burst: ARESTN low during WR_BURST with beats_left=5 -> wr_gnt=0 and beats_left=0 immediately (before next edge), IDLE after release.
